jtag_host_master: RTL and testbench

- Host-side JTAG scan engine for the on-chip probe, bench driver and loopback paths: the initiator end of the 4-wire JTAG link served by the target TAP/DTM.
- Accepts scan commands over a valid/ready interface, generates TCK/TMS/TDI from the system clock and samples TDO.
- Returns captured bits over a valid/ready response channel.
- Between commands it keeps the remote TAP parked in Run-Test/Idle.

---
 rtl/jtag_host_master.sv | 186 ++++++++++++++++++
 tb/tb_jtag_host_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_master.sv
// Host-side JTAG scan engine: turns TAP_RESET / IR_SCAN / DR_SCAN / IDLE_CYCLES commands
// into TCK/TMS/TDI sequences, captures TDO during shift bits and parks the TAP in Run-Test/Idle.
module jtag_host_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i,
  output logic              busy
);
  localparam int               PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);
  localparam logic [1:0] CMD_TAP_RESET = 2'd0;
  localparam logic [1:0] CMD_IR_SCAN   = 2'd1;
  localparam logic [1:0] CMD_DR_SCAN   = 2'd2;
  localparam logic [1:0] CMD_IDLE      = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RSP} state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [LEN_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  pre_len;
  logic [LEN_W-1:0]  shift_len;
  logic [7:0]        pre_tms;
  logic              is_scan;
  logic [DATA_W-1:0] tdi_sr;

  logic [LEN_W-1:0]  acc_pre_len;
  logic [7:0]        acc_pre_tms;
  logic              acc_scan;
  logic [LEN_W-1:0]  nxt_cnt;
  logic              half_done;

  // Scan length saturation: zero becomes one bit, oversize clamps to the bus width.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      return LEN_W'(1);
    else if (len > LEN_MAX)
      return LEN_MAX;
    else
      return len;
  endfunction

  assign nxt_cnt   = bit_cnt + LEN_W'(1);
  assign half_done = (phase == PH_LAST);

  // Header (PRE) TMS pattern per command, LSB issued first; IDLE_CYCLES reuses PRE with TMS=0.
  always_comb begin
    acc_pre_len = LEN_W'(6);
    acc_pre_tms = 8'b0001_1111;
    acc_scan    = 1'b0;
    case (cmd_type)
      CMD_TAP_RESET: ;
      CMD_IR_SCAN: begin
        acc_pre_len = LEN_W'(4);
        acc_pre_tms = 8'b0000_0011;
        acc_scan    = 1'b1;
      end
      CMD_DR_SCAN: begin
        acc_pre_len = LEN_W'(3);
        acc_pre_tms = 8'b0000_0001;
        acc_scan    = 1'b1;
      end
      CMD_IDLE: begin
        acc_pre_len = cmd_len;
        acc_pre_tms = 8'b0000_0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck_o     <= 1'b0;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b0;
      busy      <= 1'b0;
      phase     <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            pre_len   <= acc_pre_len;
            pre_tms   <= acc_pre_tms;
            is_scan   <= acc_scan;
            shift_len <= sat_len(cmd_len);
            tdi_sr    <= cmd_data;
            rsp_data  <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            tdi_o     <= 1'b0;
            if (acc_pre_len == '0) begin
              state     <= S_RSP;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_PRE;
              busy  <= 1'b1;
              tms_o <= acc_pre_tms[0];
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_PRE, S_SHIFT, S_POST: begin
          phase <= half_done ? '0 : phase + PH_W'(1);
          if (half_done && !tck_o) begin
            tck_o <= 1'b1;
            if (state == S_SHIFT)
              rsp_data <= rsp_data | (DATA_W'(tdo_i) << bit_cnt);
          end else if (half_done) begin
            // End of a bit: drop TCK and present the next bit's TMS/TDI on the same edge.
            tck_o <= 1'b0;
            if (state == S_PRE) begin
              if (nxt_cnt < pre_len) begin
                bit_cnt <= nxt_cnt;
                tms_o   <= pre_tms[nxt_cnt[2:0]];
              end else if (is_scan) begin
                state   <= S_SHIFT;
                bit_cnt <= '0;
                tms_o   <= (shift_len == LEN_W'(1));
                tdi_o   <= tdi_sr[0];
              end else begin
                state     <= S_RSP;
                rsp_valid <= 1'b1;
                busy      <= 1'b0;
              end
            end else if (state == S_SHIFT) begin
              if (nxt_cnt < shift_len) begin
                bit_cnt <= nxt_cnt;
                tms_o   <= (nxt_cnt == shift_len - LEN_W'(1));
                tdi_o   <= tdi_sr[1];
                tdi_sr  <= tdi_sr >> 1;
              end else begin
                state   <= S_POST;
                bit_cnt <= '0;
                tms_o   <= 1'b1;
                tdi_o   <= 1'b0;
              end
            end else begin
              if (bit_cnt == '0) begin
                bit_cnt <= LEN_W'(1);
                tms_o   <= 1'b0;
              end else begin
                state     <= S_RSP;
                rsp_valid <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_host_master.sv
// Directed bench for jtag_host_master: a behavioural TAP (5-bit IR, IDCODE 0x1DEAD3FF)
// answers on TDO while TCK/TMS/TDI traces and responses are compared to hand-computed values.
module tb_jtag_host_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [6:0]  cmd_len = 7'd0;
  logic [63:0] cmd_data = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        tck_o, tms_o, tdi_o;
  logic        tdo_m = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  jtag_host_master #(.CLK_DIV(2), .DATA_W(64), .LEN_W(7)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_m), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural target TAP
  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_t;
  localparam logic [4:0]  IR_IDCODE = 5'd1;
  localparam logic [31:0] IDCODE    = 32'h1DEAD3FF;

  tap_t        tap_st = TLR;
  logic [4:0]  ir = IR_IDCODE;
  logic [4:0]  ir_sr = 5'd0;
  logic [31:0] dr_sr = 32'd0;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck_o) begin
    case (tap_st)
      CAP_IR: ir_sr = 5'b00001;
      SH_IR:  ir_sr = {tdi_o, ir_sr[4:1]};
      CAP_DR: dr_sr = (ir == IR_IDCODE) ? IDCODE : 32'd0;
      SH_DR:  dr_sr = (ir == IR_IDCODE) ? {tdi_o, dr_sr[31:1]} : {31'd0, tdi_o};
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms_o);
  end

  always @(negedge tck_o) begin
    tdo_m = (tap_st == SH_DR) ? dr_sr[0] : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;
    if (tap_st == UPD_IR) ir = ir_sr;
    if (tap_st == TLR)    ir = IR_IDCODE;
  end

  // TCK trace recorder
  int           tck_cnt = 0;
  logic [127:0] tms_rec = '0;
  logic [127:0] tdi_rec = '0;

  always @(posedge tck_o) begin
    if (tck_cnt < 128) begin
      tms_rec[tck_cnt] = tms_o;
      tdi_rec[tck_cnt] = tdi_o;
    end
    tck_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d);
    int g = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = l;
    cmd_data  = d;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    tck_cnt = 0;
    tms_rec = '0;
    tdi_rec = '0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_type  = ~t;
    cmd_len   = 7'h55;
    cmd_data  = '1;
  endtask

  task automatic collect(output logic [63:0] data, output int clks);
    clks = 0;
    while (!rsp_valid && clks < 400) begin
      @(posedge clk);
      #1;
      clks++;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    data = rsp_data;
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] t, input logic [6:0] l,
                     input logic [63:0] d, input logic [63:0] exp_rsp,
                     input int exp_clks, input int exp_tcks);
    logic [63:0] r;
    int c;
    issue(t, l, d);
    collect(r, c);
    chk({tag, "_clks"}, 64'(c), 64'(exp_clks));
    chk({tag, "_tcks"}, 64'(tck_cnt), 64'(exp_tcks));
    chk({tag, "_rsp"}, r, exp_rsp);
    chk({tag, "_tck_low"}, 64'(tck_o), 64'd0);
    consume();
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] r;
    int c;
    int g;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_tck", 64'(tck_o), 64'd0);
    chk("rst_tms", 64'(tms_o), 64'd1);
    chk("rst_tdi", 64'(tdi_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    run("tap_reset", 2'd0, 7'd9, 64'hFFFF, 64'd0, 24, 6);
    chk("tap_reset_tms", tms_rec[63:0], 64'h1F);
    chk("tap_reset_state", 64'(tap_st), 64'(RTI));

    run("ir_scan", 2'd1, 7'd5, 64'h01, 64'h01, 44, 11);
    chk("ir_scan_tms", tms_rec[63:0], 64'h303);
    chk("ir_scan_tdi", tdi_rec[63:0], 64'h010);
    chk("ir_value", 64'(ir), 64'(IR_IDCODE));
    chk("ir_scan_state", 64'(tap_st), 64'(RTI));

    // DR scan of IDCODE, then response stall with a competing command
    issue(2'd2, 7'd32, 64'd0);
    collect(r, c);
    chk("dr32_clks", 64'(c), 64'd148);
    chk("dr32_tcks", 64'(tck_cnt), 64'd37);
    chk("dr32_rsp", r, 64'h1DEAD3FF);
    chk("dr32_tms", tms_rec[63:0], 64'hC_0000_0001);
    chk("dr32_tdi", tdi_rec[63:0], 64'd0);
    held = rsp_data;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = 2'd3;
    cmd_len   = 7'd3;
    cmd_data  = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_data", rsp_data, held);
    end
    tck_cnt = 0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("acc_busy", 64'(busy), 64'd1);
    chk("acc_cmd_ready", 64'(cmd_ready), 64'd0);
    collect(r, c);
    chk("idle3_clks", 64'(c), 64'd12);
    chk("idle3_tcks", 64'(tck_cnt), 64'd3);
    chk("idle3_rsp", r, 64'd0);
    chk("idle3_busy", 64'(busy), 64'd0);
    consume();

    // Length boundaries
    run("dr_len0", 2'd2, 7'd0, 64'd0, 64'd1, 24, 6);
    run("dr_len100", 2'd2, 7'd100, 64'h12345678_CAFEF00D, 64'hCAFEF00D_1DEAD3FF, 276, 69);
    run("idle_len0", 2'd3, 7'd0, 64'hABCD, 64'd0, 0, 0);
    chk("idle_len0_state", 64'(tap_st), 64'(RTI));

    // Reset in the middle of shift bit 10 of a 32-bit DR scan
    issue(2'd2, 7'd32, 64'd0);
    g = 0;
    while (tck_cnt < 14 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("mid_wait", 64'(tck_cnt), 64'd14);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tck", 64'(tck_o), 64'd0);
    chk("mid_rst_tms", 64'(tms_o), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rsp_data", rsp_data, 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run("rec_tap_reset", 2'd0, 7'd0, 64'd0, 64'd0, 24, 6);
    chk("rec_state", 64'(tap_st), 64'(RTI));
    run("rec_dr32", 2'd2, 7'd32, 64'd0, 64'h1DEAD3FF, 148, 37);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
